// File: rtl/pio_shift_out_if.sv
// Parallel PIO value in, 74HC595-style serial shift/latch signals out.
// The design sits on the slave side. The bench drives pio_in from the master side.
interface pio_shift_out_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] pio_in;
   logic             sclk;
   logic             sdata;
   logic             rclk;
   logic             busy;
   logic             done;

   modport master (
      output pio_in,
      input  sclk, sdata, rclk, busy, done
   );

   modport slave (
      input  pio_in,
      output sclk, sdata, rclk, busy, done
   );
endinterface

// File: rtl/pio_shift_out.sv
// Serialises the PIO value MSB-first into an external shift/latch register chain.
// A new frame is sent after every reset and whenever pio_in differs from the last value sent.
module pio_shift_out #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input logic             clk,
   input logic             reset_n,
   pio_shift_out_if.slave  bus
);
   localparam int              BW       = $clog2(WIDTH + 1);
   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] shreg_next;
   logic             force_tx;
   logic [7:0]       div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             phase_end;
   logic             sclk_r;
   logic             sdata_r;
   logic             rclk_r;
   logic             busy_r;
   logic             done_r;

   assign shreg_next = shreg << 1;
   assign phase_end  = (div_cnt == DIV_LAST);

   assign bus.sclk  = sclk_r;
   assign bus.sdata = sdata_r;
   assign bus.rclk  = rclk_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         shreg    <= '0;
         shadow   <= '0;
         force_tx <= 1'b1;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         sclk_r   <= 1'b0;
         sdata_r  <= 1'b0;
         rclk_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               // Only compare against what was last sent; changes during a frame are not queued.
               if (force_tx || (bus.pio_in != shadow)) begin
                  shreg    <= bus.pio_in;
                  shadow   <= bus.pio_in;
                  force_tx <= 1'b0;
                  bit_cnt  <= BIT_LAST;
                  div_cnt  <= '0;
                  busy_r   <= 1'b1;
                  sdata_r  <= bus.pio_in[WIDTH-1];
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (phase_end) begin
                  div_cnt <= '0;
                  sclk_r  <= 1'b1;
                  state   <= HIGH;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  div_cnt <= '0;
                  sclk_r  <= 1'b0;
                  if (bit_cnt == '0) begin
                     rclk_r <= 1'b1;
                     state  <= LATCH;
                  end else begin
                     // Next bit is presented on the falling edge, a full phase before the next rise.
                     shreg   <= shreg_next;
                     bit_cnt <= bit_cnt - BW'(1);
                     sdata_r <= shreg_next[WIDTH-1];
                     state   <= SETUP;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            LATCH: begin
               if (phase_end) begin
                  div_cnt <= '0;
                  rclk_r  <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state   <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pio_shift_out.sv
// Randomised scoreboard bench for pio_shift_out: one instance at CLK_DIV=4, one at CLK_DIV=1.
// A frame-timing reference model predicts every output cycle and the byte carried by each frame.
module tb_pio_shift_out;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [W-1:0] pio0 = '0;
   logic [W-1:0] pio1 = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pio_shift_out_if #(.WIDTH(W)) bus0 ();
   pio_shift_out_if #(.WIDTH(W)) bus1 ();

   assign bus0.pio_in = pio0;
   assign bus1.pio_in = pio1;

   pio_shift_out #(.WIDTH(W), .CLK_DIV(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
   pio_shift_out #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

   logic [1:0] sclk_s, sdata_s, rclk_s, busy_s, done_s;
   assign sclk_s  = {bus1.sclk,  bus0.sclk};
   assign sdata_s = {bus1.sdata, bus0.sdata};
   assign rclk_s  = {bus1.rclk,  bus0.rclk};
   assign busy_s  = {bus1.busy,  bus0.busy};
   assign done_s  = {bus1.done,  bus0.done};

   task automatic chk(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int frame_of(input int i);
      return (2 * W + 1) * div_of(i);
   endfunction

   function automatic logic [W-1:0] pio_of(input int i);
      return (i == 0) ? pio0 : pio1;
   endfunction

   // Reference model: a frame is a fixed-length window of (2W+1)*DIV cycles after a capture.
   int           rem[2];
   bit           frc[2];
   bit           exp_done[2];
   logic [W-1:0] shd[2];
   logic [W-1:0] cur[2];
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            if (rem[i] > 0) begin
               if (i == 0) void'(q0.pop_back());
               else        void'(q1.pop_back());
            end
            rem[i] = 0; frc[i] = 1'b1; shd[i] = '0; exp_done[i] = 1'b0;
         end else begin
            exp_done[i] = 1'b0;
            if (rem[i] == 0) begin
               if (frc[i] || (pio_of(i) != shd[i])) begin
                  cur[i] = pio_of(i);
                  shd[i] = cur[i];
                  frc[i] = 1'b0;
                  rem[i] = frame_of(i);
                  if (i == 0) q0.push_back(cur[i]);
                  else        q1.push_back(cur[i]);
               end
            end else begin
               rem[i] = rem[i] - 1;
               if (rem[i] == 0) exp_done[i] = 1'b1;
            end
         end
      end
   end

   // Monitor: per-cycle waveform checks plus frame reassembly popped against the scoreboard.
   logic [W-1:0] got_bits[2];
   int           nbits[2];
   bit           prev_sclk[2];
   bit           prev_rclk[2];
   bit           prev_sdata[2];
   int           rclk_len[2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int t, ph;
         bit e_sclk, e_rclk, e_busy;
         logic [W-1:0] exp_v;
         if (!reset_n) begin
            chk("rst_sclk", i, sclk_s[i], 0);
            chk("rst_sdata", i, sdata_s[i], 0);
            chk("rst_rclk", i, rclk_s[i], 0);
            chk("rst_busy", i, busy_s[i], 0);
            chk("rst_done", i, done_s[i], 0);
            nbits[i] = 0; got_bits[i] = '0; rclk_len[i] = 0;
            prev_sclk[i] = 1'b0; prev_rclk[i] = 1'b0;
         end else begin
            t  = frame_of(i) - rem[i];
            ph = t / div_of(i);
            e_busy = (rem[i] > 0);
            e_sclk = e_busy && (ph < 2 * W) && (ph % 2 == 1);
            e_rclk = e_busy && (ph == 2 * W);
            chk("busy", i, busy_s[i], e_busy);
            chk("sclk", i, sclk_s[i], e_sclk);
            chk("rclk", i, rclk_s[i], e_rclk);
            chk("done", i, done_s[i], exp_done[i]);
            if (e_busy && ph < 2 * W)
               chk("sdata", i, sdata_s[i], cur[i][W - 1 - ph / 2]);
            if (sclk_s[i] && prev_sclk[i])
               chk("sdata_stable_high", i, sdata_s[i], prev_sdata[i]);
            if (sclk_s[i] && !prev_sclk[i]) begin
               got_bits[i] = {got_bits[i][W-2:0], sdata_s[i]};
               nbits[i]++;
            end
            if (rclk_s[i] && !prev_rclk[i]) chk("bits_before_latch", i, nbits[i], W);
            if (rclk_s[i]) rclk_len[i]++;
            if (done_s[i]) begin
               if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                  chk("unexpected_frame", i, 1, 0);
               end else begin
                  exp_v = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk("frame_value", i, got_bits[i], exp_v);
               end
               chk("rclk_width", i, rclk_len[i], div_of(i));
               nbits[i] = 0; rclk_len[i] = 0;
            end
            prev_sclk[i]  = sclk_s[i];
            prev_rclk[i]  = rclk_s[i];
            prev_sdata[i] = sdata_s[i];
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt, dones, rises;
      bit ps;
      pio0 = 8'hFF;
      pio1 = 8'h00;
      step(3);
      reset_n = 1'b1;
      step(80);

      pio0 = 8'hA5;
      step(80);

      // Several changes during one frame: only the last one follows.
      pio0 = 8'hC3;
      step(10);
      pio0 = 8'h01;
      step(10);
      pio0 = 8'h02;
      step(10);
      pio0 = 8'h3C;
      step(160);

      dones = 0; rises = 0; ps = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (done_s[0]) dones++;
         if (sclk_s[0] && !ps) rises++;
         ps = sclk_s[0];
      end
      chk("quiet_done_pulses", 0, dones, 0);
      chk("quiet_sclk_rises", 0, rises, 0);

      // Reset on the 5th rising sclk edge of a 5A frame.
      step(1);
      pio0 = 8'h5A;
      cnt = 0; ps = 1'b0;
      for (int k = 0; k < 200 && cnt < 5; k++) begin
         @(negedge clk);
         if (sclk_s[0] && !ps) cnt++;
         ps = sclk_s[0];
      end
      chk("fifth_edge_seen", 0, cnt, 5);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_sclk", 0, bus0.sclk, 0);
      chk("async_rst_sdata", 0, bus0.sdata, 0);
      chk("async_rst_rclk", 0, bus0.rclk, 0);
      chk("async_rst_busy", 0, bus0.busy, 0);
      chk("async_rst_done", 0, bus0.done, 0);
      step(3);
      reset_n = 1'b1;
      step(80);

      pio1 = 8'h80;
      step(30);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) != 0) pio0 = W'($urandom);
         if ($urandom_range(0, 3) != 0) pio1 = W'($urandom);
         step($urandom_range(1, 90));
      end
      step(100);
      chk("pending_frames_dut0", 0, q0.size(), 0);
      chk("pending_frames_dut1", 1, q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
